// File: rtl/dt_pkg.sv
// Shared constants, FSM encoding and address-map helpers for the chessboard distance transform.
package dt_pkg;

  localparam int unsigned IMG_W  = 128;
  localparam int unsigned IMG_H  = 128;
  localparam int unsigned DIST_W = 8;
  localparam int unsigned ROW_W  = 7;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned STI_AW = 10;
  localparam int unsigned RES_AW = 14;
  localparam int unsigned NB_NUM = 5;

  typedef enum logic [3:0] {
    StIdle,
    StFwLoad,
    StFwLatch,
    StFwPix,
    StFwRead,
    StFwWait,
    StFwWrite,
    StBwLoad,
    StBwLatch,
    StBwPix,
    StBwRead,
    StBwWait,
    StBwWrite,
    StDone
  } dt_state_e;

  typedef struct packed {
    logic              valid;
    logic [RES_AW-1:0] addr;
  } nb_ref_t;

  function automatic logic [STI_AW-1:0] sti_word_addr(input logic [ROW_W-1:0] row,
                                                      input logic [COL_W-1:0] col);
    return {row, col[COL_W-1:4]};
  endfunction

  function automatic logic [RES_AW-1:0] res_pix_addr(input logic [ROW_W-1:0] row,
                                                     input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

  function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Forward slots: NW, N, NE, W. Backward slots: E, SW, S, SE, cur.
  function automatic nb_ref_t nb_lookup(input logic             bw,
                                        input logic [2:0]       k,
                                        input logic [ROW_W-1:0] row,
                                        input logic [COL_W-1:0] col);
    int      dr;
    int      dc;
    int      r;
    int      c;
    nb_ref_t nb;
    dr = 0;
    dc = 0;
    if (!bw) begin
      case (k)
        3'd0:    begin dr = -1; dc = -1; end
        3'd1:    dr = -1;
        3'd2:    begin dr = -1; dc = 1; end
        default: dc = -1;
      endcase
    end else begin
      case (k)
        3'd0:    dc = 1;
        3'd1:    begin dr = 1; dc = -1; end
        3'd2:    dr = 1;
        3'd3:    begin dr = 1; dc = 1; end
        default: ;
      endcase
    end
    r = int'(row) + dr;
    c = int'(col) + dc;
    nb.valid = (r >= 0) && (r < int'(IMG_H)) && (c >= 0) && (c < int'(IMG_W));
    nb.addr  = {r[ROW_W-1:0], c[COL_W-1:0]};
    return nb;
  endfunction

endpackage

// File: rtl/dt_min4.sv
// Combinational unsigned minimum of four distance values.
module dt_min4
  import dt_pkg::*;
(
  input  logic [DIST_W-1:0] a,
  input  logic [DIST_W-1:0] b,
  input  logic [DIST_W-1:0] c,
  input  logic [DIST_W-1:0] d,
  output logic [DIST_W-1:0] y
);

  logic [DIST_W-1:0] ab;
  logic [DIST_W-1:0] cd;

  always_comb begin
    ab = (a < b) ? a : b;
    cd = (c < d) ? c : d;
    y  = (ab < cd) ? ab : cd;
  end

endmodule

// File: rtl/distance_transform.sv
// Two-pass chessboard distance transform: ROM bitmap in, 8-bit distances written to the RAM.
module distance_transform
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic              done,
  output logic              sti_rd,
  output logic [STI_AW-1:0] sti_addr,
  input  logic [WORD_W-1:0] sti_di,
  output logic              res_wr,
  output logic              res_rd,
  output logic [RES_AW-1:0] res_addr,
  output logic [DIST_W-1:0] res_do,
  input  logic [DIST_W-1:0] res_di
);

  dt_state_e state_q, state_d;
  // Flat pixel index row*128+col; doubles as the RAM address.
  logic [RES_AW-1:0] pix_q, pix_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [2:0]        k_q, k_d;
  logic [NB_NUM-1:0][DIST_W-1:0] nb_q, nb_d;
  logic              done_q, done_d;
  logic              sti_rd_q, sti_rd_d;
  logic [STI_AW-1:0] sti_addr_q, sti_addr_d;
  logic              res_wr_q, res_wr_d;
  logic              res_rd_q, res_rd_d;
  logic [RES_AW-1:0] res_addr_q, res_addr_d;
  logic [DIST_W-1:0] res_do_q, res_do_d;

  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              bw;
  logic [2:0]        k_last;
  nb_ref_t           nb;
  dt_state_e         fw_next, bw_next;
  logic [RES_AW-1:0] fw_pix, bw_pix;
  logic [DIST_W-1:0] m_a, m_b, m_c, m_d, m_y;
  logic [DIST_W-1:0] fw_val, bw_val;

  assign row    = pix_q[RES_AW-1:COL_W];
  assign col    = pix_q[COL_W-1:0];
  assign bw     = state_q inside {StBwLoad, StBwLatch, StBwPix, StBwRead, StBwWait, StBwWrite};
  assign k_last = bw ? 3'd4 : 3'd3;
  assign nb     = nb_lookup(bw, k_q, row, col);

  // The backward pass compares neighbour+1; the forward pass adds 1 after the compare.
  always_comb begin
    m_a = bw ? sat_inc(nb_q[0]) : nb_q[0];
    m_b = bw ? sat_inc(nb_q[1]) : nb_q[1];
    m_c = bw ? sat_inc(nb_q[2]) : nb_q[2];
    m_d = bw ? sat_inc(nb_q[3]) : nb_q[3];
  end

  dt_min4 u_min4 (
    .a(m_a),
    .b(m_b),
    .c(m_c),
    .d(m_d),
    .y(m_y)
  );

  assign fw_val = sat_inc(m_y);
  assign bw_val = (nb_q[4] < m_y) ? nb_q[4] : m_y;

  always_comb begin
    fw_next = StFwPix;
    if (pix_q == '1) begin
      fw_next = StBwLoad;
    end else if (pix_q[3:0] == 4'hF) begin
      fw_next = StFwLoad;
    end
    bw_next = StBwPix;
    if (pix_q == '0) begin
      bw_next = StDone;
    end else if (pix_q[3:0] == 4'h0) begin
      bw_next = StBwLoad;
    end
  end

  assign fw_pix = (pix_q == '1) ? pix_q : pix_q + 1'b1;
  assign bw_pix = (pix_q == '0) ? pix_q : pix_q - 1'b1;

  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    word_d     = word_q;
    k_d        = k_q;
    nb_d       = nb_q;
    done_d     = done_q;
    sti_rd_d   = 1'b0;
    sti_addr_d = sti_addr_q;
    res_wr_d   = 1'b0;
    res_rd_d   = 1'b0;
    res_addr_d = res_addr_q;
    res_do_d   = res_do_q;

    unique case (state_q)
      StIdle: begin
        pix_d   = '0;
        state_d = StFwLoad;
      end
      StFwLoad, StBwLoad: begin
        sti_rd_d   = 1'b1;
        sti_addr_d = sti_word_addr(row, col);
        state_d    = bw ? StBwLatch : StFwLatch;
      end
      StFwLatch: begin
        word_d  = sti_di;
        state_d = StFwPix;
      end
      StBwLatch: begin
        word_d = sti_di;
        if (sti_di != '0) begin
          state_d = StBwPix;
        end else if (pix_q[RES_AW-1:4] == '0) begin
          state_d = StDone;
        end else begin
          // All-background word: background is already final, jump to the next word.
          pix_d   = pix_q - RES_AW'(WORD_W);
          state_d = StBwLoad;
        end
      end
      StFwPix: begin
        if (word_q[WORD_W-1]) begin
          k_d     = '0;
          state_d = StFwRead;
        end else begin
          res_wr_d   = 1'b1;
          res_addr_d = res_pix_addr(row, col);
          res_do_d   = '0;
          word_d     = word_q << 1;
          pix_d      = fw_pix;
          state_d    = fw_next;
        end
      end
      StBwPix: begin
        if (word_q[0]) begin
          k_d     = '0;
          state_d = StBwRead;
        end else begin
          word_d  = word_q >> 1;
          pix_d   = bw_pix;
          state_d = bw_next;
        end
      end
      StFwRead, StBwRead: begin
        if (k_q > k_last) begin
          state_d = bw ? StBwWrite : StFwWrite;
        end else if (nb.valid) begin
          res_rd_d   = 1'b1;
          res_addr_d = nb.addr;
          state_d    = bw ? StBwWait : StFwWait;
        end else begin
          nb_d[k_q] = '0;
          k_d       = k_q + 1'b1;
        end
      end
      StFwWait, StBwWait: begin
        nb_d[k_q] = res_di;
        k_d       = k_q + 1'b1;
        state_d   = bw ? StBwRead : StFwRead;
      end
      StFwWrite: begin
        res_wr_d   = 1'b1;
        res_addr_d = res_pix_addr(row, col);
        res_do_d   = fw_val;
        word_d     = word_q << 1;
        pix_d      = fw_pix;
        state_d    = fw_next;
      end
      StBwWrite: begin
        res_wr_d   = 1'b1;
        res_addr_d = res_pix_addr(row, col);
        res_do_d   = bw_val;
        word_d     = word_q >> 1;
        pix_d      = bw_pix;
        state_d    = bw_next;
      end
      // Entered one cycle before the last write lands, so done rises with the RAM final.
      StDone: begin
        done_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      pix_q      <= '0;
      word_q     <= '0;
      k_q        <= '0;
      nb_q       <= '0;
      done_q     <= 1'b0;
      sti_rd_q   <= 1'b0;
      sti_addr_q <= '0;
      res_wr_q   <= 1'b0;
      res_rd_q   <= 1'b0;
      res_addr_q <= '0;
      res_do_q   <= '0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      word_q     <= word_d;
      k_q        <= k_d;
      nb_q       <= nb_d;
      done_q     <= done_d;
      sti_rd_q   <= sti_rd_d;
      sti_addr_q <= sti_addr_d;
      res_wr_q   <= res_wr_d;
      res_rd_q   <= res_rd_d;
      res_addr_q <= res_addr_d;
      res_do_q   <= res_do_d;
    end
  end

  assign done     = done_q;
  assign sti_rd   = sti_rd_q;
  assign sti_addr = sti_addr_q;
  assign res_wr   = res_wr_q;
  assign res_rd   = res_rd_q;
  assign res_addr = res_addr_q;
  assign res_do   = res_do_q;

endmodule

// File: tb/tb_distance_transform.sv
// Bench for distance_transform: ROM/RAM models, brute-force chessboard reference, spot table.
`timescale 1ns/1ps
module tb_distance_transform;

  logic        clk;
  logic        reset;
  logic        done;
  logic        sti_rd;
  logic [9:0]  sti_addr;
  logic [15:0] sti_di;
  logic        res_wr;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_do;
  logic [7:0]  res_di;

  typedef struct {
    int         row;
    int         col;
    logic [7:0] exp;
  } spot_t;

  spot_t       spots[$];
  logic        img[128][128];
  logic [15:0] rom[1024];
  logic [7:0]  ram[16384];
  logic [7:0]  exp_mem[16384];
  logic [7:0]  sb_q[$];
  logic        fill_ram;
  int          checks;
  int          errors;
  int          rw_conflicts;
  int          writes_after_done;

  distance_transform u_dut (
    .clk(clk),
    .reset(reset),
    .done(done),
    .sti_rd(sti_rd),
    .sti_addr(sti_addr),
    .sti_di(sti_di),
    .res_wr(res_wr),
    .res_rd(res_rd),
    .res_addr(res_addr),
    .res_do(res_do),
    .res_di(res_di)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sti_rd) sti_di <= rom[sti_addr];
    if (res_rd) res_di <= ram[res_addr];
  end

  initial begin
    rw_conflicts      = 0;
    writes_after_done = 0;
  end

  always @(posedge clk) begin
    if (fill_ram) begin
      for (int i = 0; i < 16384; i++) ram[i] <= 8'hAA;
    end else if (res_wr) begin
      ram[res_addr] <= res_do;
    end
    if (res_wr && res_rd) rw_conflicts <= rw_conflicts + 1;
    if (done && res_wr) writes_after_done <= writes_after_done + 1;
  end

  function automatic void clear_img();
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 128; c++) img[r][c] = 1'b0;
  endfunction

  function automatic void set_rect(input int r0, input int r1, input int c0, input int c1);
    for (int r = r0; r <= r1; r++)
      for (int c = c0; c <= c1; c++) img[r][c] = 1'b1;
  endfunction

  function automatic void build_rom();
    for (int w = 0; w < 1024; w++) rom[w] = 16'h0000;
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 128; c++) rom[r*8 + c/16][15 - (c%16)] = img[r][c];
  endfunction

  // Chessboard distance to the nearest background pixel; outside the image is background.
  function automatic logic [7:0] model_dist(input int r, input int c);
    int d;
    if (!img[r][c]) return 8'h00;
    d = r + 1;
    if (c + 1 < d) d = c + 1;
    if (128 - r < d) d = 128 - r;
    if (128 - c < d) d = 128 - c;
    for (int rad = 1; rad < d; rad++)
      for (int dr = -rad; dr <= rad; dr++)
        for (int dc = -rad; dc <= rad; dc++)
          if ((dr == rad || dr == -rad || dc == rad || dc == -rad) && !img[r+dr][c+dc])
            return 8'(rad);
    return 8'(d);
  endfunction

  function automatic void build_expected();
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 128; c++) exp_mem[r*128 + c] = model_dist(r, c);
  endfunction

  task automatic check_reset_outputs(input string tag);
    logic [35:0] got;
    got = {done, sti_rd, res_wr, res_rd, sti_addr, res_addr, res_do};
    checks++;
    if (got !== 36'h0) begin
      errors++;
      $display("FAIL %s: outputs {done,sti_rd,res_wr,res_rd,sti_addr,res_addr,res_do} = %h, expected 0",
               tag, got);
    end
  endtask

  task automatic run_and_check(input string tag);
    int         cyc;
    int         bad_c;
    logic [7:0] e;
    logic [7:0] bad_got;
    logic [7:0] bad_exp;
    for (int i = 0; i < 16384; i++) sb_q.push_back(exp_mem[i]);
    cyc = 0;
    while (done !== 1'b1 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_timeout: done=%b after %0d cycles, expected 1", tag, done, cyc);
      sb_q.delete();
      return;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_sticky: done=%b, expected 1", tag, done);
    end
    for (int r = 0; r < 128; r++) begin
      bad_c   = -1;
      bad_got = 8'h00;
      bad_exp = 8'h00;
      for (int c = 0; c < 128; c++) begin
        e = sb_q.pop_front();
        if (bad_c < 0 && ram[r*128 + c] !== e) begin
          bad_c   = c;
          bad_got = ram[r*128 + c];
          bad_exp = e;
        end
      end
      checks++;
      if (bad_c >= 0) begin
        errors++;
        $display("FAIL %s ram_row %0d col %0d: got %02h, expected %02h", tag, r, bad_c,
                 bad_got, bad_exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    spots.push_back(spot_t'{5, 5, 8'h01});
    spots.push_back(spot_t'{5, 6, 8'h00});
    spots.push_back(spot_t'{4, 5, 8'h00});
    spots.push_back(spot_t'{20, 20, 8'h01});
    spots.push_back(spot_t'{20, 24, 8'h01});
    spots.push_back(spot_t'{24, 22, 8'h01});
    spots.push_back(spot_t'{21, 21, 8'h02});
    spots.push_back(spot_t'{21, 23, 8'h02});
    spots.push_back(spot_t'{23, 22, 8'h02});
    spots.push_back(spot_t'{22, 22, 8'h03});
    spots.push_back(spot_t'{19, 22, 8'h00});
    spots.push_back(spot_t'{40, 10, 8'h01});
    spots.push_back(spot_t'{40, 55, 8'h01});
    spots.push_back(spot_t'{40, 100, 8'h01});
    spots.push_back(spot_t'{40, 101, 8'h00});
    spots.push_back(spot_t'{39, 50, 8'h00});
    spots.push_back(spot_t'{1, 0, 8'h01});
    spots.push_back(spot_t'{1, 15, 8'h01});
    spots.push_back(spot_t'{1, 1, 8'h00});
    spots.push_back(spot_t'{1, 14, 8'h00});
    spots.push_back(spot_t'{110, 0, 8'h01});
    spots.push_back(spot_t'{127, 0, 8'h01});
    spots.push_back(spot_t'{120, 11, 8'h01});
    spots.push_back(spot_t'{113, 3, 8'h04});
    spots.push_back(spot_t'{118, 5, 8'h06});

    fill_ram = 1'b0;
    reset    = 1'b1;
    #3 reset = 1'b0;
    clear_img();
    build_rom();
    build_expected();
    @(negedge clk) fill_ram = 1'b1;
    @(negedge clk) fill_ram = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_idle");
    reset = 1'b1;
    run_and_check("zero_img");

    clear_img();
    set_rect(5, 5, 5, 5);
    set_rect(20, 24, 20, 24);
    set_rect(40, 40, 10, 100);
    set_rect(1, 1, 0, 0);
    set_rect(1, 1, 15, 15);
    set_rect(110, 127, 0, 11);
    build_rom();
    build_expected();
    @(negedge clk) reset = 1'b0;
    #1 check_reset_outputs("done_clear");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4000) @(negedge clk);
    reset = 1'b0;
    #1 check_reset_outputs("abort_mid_fw");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    run_and_check("obj_img");

    for (int i = 0; i < spots.size(); i++) begin
      checks++;
      if (ram[spots[i].row*128 + spots[i].col] !== spots[i].exp) begin
        errors++;
        $display("FAIL spot (%0d,%0d): got %02h, expected %02h", spots[i].row, spots[i].col,
                 ram[spots[i].row*128 + spots[i].col], spots[i].exp);
      end
    end

    checks++;
    if (rw_conflicts != 0) begin
      errors++;
      $display("FAIL rd_wr_overlap: %0d cycles with res_rd and res_wr both high, expected 0",
               rw_conflicts);
    end
    checks++;
    if (writes_after_done != 0) begin
      errors++;
      $display("FAIL write_after_done: %0d RAM writes while done high, expected 0",
               writes_after_done);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
